// File: rtl/rvm_mem_responder.sv
// Memory-side responder for the core mem_* bus: word RAM with byte writes,
// a fixed number of wait states per access and address range/alignment checking.
module rvm_mem_responder #(
  parameter int unsigned DEPTH       = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic        mem_c_en,
  input  logic [3:0]  mem_b_en,
  output logic [31:0] mem_rdata,
  output logic        mem_error,
  output logic        mem_stall
);

  localparam int unsigned AW      = $clog2(DEPTH);
  localparam logic [3:0]  WAIT_LD = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state_q;
  logic [3:0]  count_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  be_q;
  logic [31:0] rdata_q;
  logic        error_q;
  logic [31:0] ram_q [DEPTH];

  logic          accept;
  logic          finish;
  logic          acc_err;
  logic          do_write;
  logic [31:0]   acc_addr;
  logic [31:0]   acc_wdata;
  logic [31:0]   acc_off;
  logic [3:0]    acc_be;
  logic [AW-1:0] acc_idx;

  // With zero wait states the access completes on the accept edge, so the
  // live bus values stand in for the not-yet-captured request registers.
  always_comb begin
    accept    = (state_q == IDLE) && mem_c_en;
    finish    = (accept && (WAIT_CYCLES == 0)) ||
                ((state_q == BUSY) && mem_c_en && (count_q == 4'd1));
    acc_addr  = accept ? mem_addr  : addr_q;
    acc_wdata = accept ? mem_wdata : wdata_q;
    acc_be    = accept ? mem_b_en  : be_q;
    acc_off   = acc_addr - BASE_ADDR;
    acc_err   = (acc_addr[1:0] != 2'b00) || ((acc_off >> (AW + 2)) != 32'd0);
    acc_idx   = acc_off[AW+1:2];
    do_write  = resetn && finish && !acc_err && (acc_be != 4'b0000);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      count_q <= '0;
      rdata_q <= '0;
      error_q <= 1'b0;
    end else begin
      error_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (mem_c_en) begin
            addr_q  <= mem_addr;
            wdata_q <= mem_wdata;
            be_q    <= mem_b_en;
            count_q <= WAIT_LD;
            state_q <= (WAIT_CYCLES == 0) ? DONE : BUSY;
          end
        end
        BUSY: begin
          if (!mem_c_en) begin
            state_q <= IDLE;
          end else begin
            count_q <= count_q - 4'd1;
            if (count_q == 4'd1) state_q <= DONE;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
      if (finish) begin
        if (acc_err) begin
          rdata_q <= '0;
          error_q <= 1'b1;
        end else if (acc_be == 4'b0000) begin
          rdata_q <= ram_q[acc_idx];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_write) begin
      for (int b = 0; b < 4; b++) begin
        if (acc_be[b]) ram_q[acc_idx][8*b +: 8] <= acc_wdata[8*b +: 8];
      end
    end
  end

  assign mem_rdata = rdata_q;
  assign mem_error = error_q;
  assign mem_stall = resetn && mem_c_en && (state_q != DONE);

endmodule

// File: doc/rvm_mem_responder.md
Name: rvm_mem_responder

Overview:
- Memory-side responder for the core's `mem_*` bus. It receives the core's requests (addr, wdata, chip enable, byte enable) and drives back read data, stall and error.
- Backed by a word-addressed on-chip RAM, with a programmable wait-state counter and address checking.
- Used as the instruction/data memory in core-level simulation and FPGA builds; sits directly opposite the core's memory port.

Parameters:
- DEPTH, 1024, number of 32-bit words in the RAM (power of two, ≥4).
- BASE_ADDR, 32'h0000_0000, byte address of word 0 (aligned to 4*DEPTH).
- WAIT_CYCLES, 1, extra stall cycles inserted per access (0..15).

Ports:
- clk  input  1  system clock.
- resetn  input  1  synchronous active-low reset, sampled on rising edge of clk.
- mem_addr  input  32  byte address from core.
- mem_wdata  input  32  write data from core.
- mem_c_en  input  1  request valid; held high by core until completion.
- mem_b_en  input  4  byte enables; 4'b0000 = word read, non-zero = write of enabled bytes (bit i -> wdata[8i+7:8i]).
- mem_rdata  output  32  read data, valid in completion cycle.
- mem_error  output  1  access error, valid in completion cycle only.
- mem_stall  output  1  core must hold request while high.

Behaviour:
- Reset (resetn=0 at posedge):
  - state=IDLE, counter=0, mem_rdata=0, mem_error=0.
  - mem_stall forced 0 while resetn=0.
  - RAM contents are not cleared.
- FSM states: IDLE, BUSY, DONE.
- mem_stall = mem_c_en && state!=DONE (combinational from registered state and c_en); 0 in DONE.
- IDLE:
  - On c_en=1, capture addr, wdata and b_en into request registers; load counter=WAIT_CYCLES.
  - Next state is BUSY if WAIT_CYCLES>0, else DONE.
  - The accept cycle always shows stall=1.
- BUSY:
  - Counter decrements each cycle; on counter==1 go to DONE.
  - If c_en drops, abort: go to IDLE, no RAM write, error stays 0.
- Transition into DONE (same clock edge):
  - Error check on captured request. Error if addr[1:0]!=0 or addr outside [BASE_ADDR, BASE_ADDR+4*DEPTH).
  - No error, read: mem_rdata <= RAM[(addr-BASE_ADDR)>>2].
  - No error, write: update only the enabled bytes; mem_rdata unchanged.
  - Error: no RAM write, mem_rdata <= 0, mem_error <= 1.
- DONE:
  - Lasts exactly one cycle; stall=0, so the core retires the access.
  - Next state IDLE; mem_error cleared to 0 on leaving DONE.
  - mem_rdata holds its value until the next read completion, error or reset.
- Latency: completion cycle = accept cycle + 1 + WAIT_CYCLES (min 2 cycles per access).
- Back-to-back: if c_en is still high in the IDLE cycle after DONE, that is a new request (accepted, stall=1).
- Changes on addr/wdata/b_en after accept are ignored; the captured values are used.
- Write then read of same word returns the new data (write commits at the DONE-entry edge).
- Reset mid-access (any state): return to IDLE next edge, pending write discarded, outputs to reset values.
- RAM index uses bits [log2(DEPTH)+1:2] of (addr-BASE_ADDR).

Test Plan:
- Write/read, WAIT_CYCLES=1: write addr 0x10, wdata 0xDEADBEEF, b_en 4'hF.
  - Expect stall=1 for 2 cycles, then DONE.
  - Read 0x10 with b_en 0 -> rdata 0xDEADBEEF in completion cycle, error 0.
- Byte enables: word 0x20 holds 0x11223344; write wdata 0xAABBCCDD, b_en 4'b0101 -> read 0x20 returns 0x11BB33DD.
- Wait states, WAIT_CYCLES=3: read request held -> exactly 4 stall cycles, rdata valid in 5th cycle; WAIT_CYCLES=0 -> 1 stall cycle.
- Errors (DEPTH=1024, BASE 0):
  - Read 0x1000 -> error=1 for one cycle, rdata 0.
  - Write 0x0000_0012 -> error=1, word 0x10 unchanged on readback.
- Abort: WAIT_CYCLES=3, write to 0x30 with c_en dropped after 2 cycles -> no error; readback of 0x30 shows old value.
- Reset and back-to-back:
  - resetn=0 during BUSY of a write -> stall 0, error 0, rdata 0; write not committed.
  - Two reads with c_en held high throughout -> second accepted the cycle after the first DONE.
